// File: rtl/eta2_error_monitor.sv
// ETA2 approximate-adder error monitor. Two-stage valid/ready pipeline that
// compares the ETA2 sum against the exact sum and accumulates error statistics.
module eta2_error_monitor #(
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic             cin,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [16:0]      approx_sum,
  output logic [16:0]      exact_sum,
  output logic [16:0]      err_dist,
  output logic             err_flag,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [16:0]      max_ed,
  output logic [ACC_W-1:0] sum_ed
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic        s1_valid;
  logic [16:0] s1_approx;
  logic [16:0] s1_exact;
  logic        s1_load;
  logic        s2_load;
  logic        out_xfer;
  logic [4:0]  carry;
  logic [15:0] y;
  logic [16:0] approx_c;
  logic [16:0] exact_c;
  logic [16:0] dist_c;
  logic [ACC_W:0] sum_next;

  // Each block's carry into the next comes only from its own a+b, never rippled.
  always_comb begin
    logic [4:0] blk;
    blk   = '0;
    carry = {4'b0, cin};
    y     = '0;
    for (int k = 0; k < 4; k++) begin
      blk          = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]};
      carry[k+1]   = blk[4];
      y[4*k +: 4]  = blk[3:0] + {3'b0, carry[k]};
    end
  end

  assign approx_c = {carry[4], y};
  assign exact_c  = {1'b0, a} + {1'b0, b} + {16'b0, cin};
  assign dist_c   = (s1_exact >= s1_approx) ? (s1_exact - s1_approx) : (s1_approx - s1_exact);

  assign out_xfer = out_valid && out_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign sum_next = {1'b0, sum_ed} + {{(ACC_W-16){1'b0}}, err_dist};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_approx <= '0;
      s1_exact  <= '0;
    end else if (s1_load) begin
      s1_valid  <= 1'b1;
      s1_approx <= approx_c;
      s1_exact  <= exact_c;
    end else if (s2_load) begin
      s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      approx_sum <= '0;
      exact_sum  <= '0;
      err_dist   <= '0;
      err_flag   <= 1'b0;
    end else if (s2_load) begin
      out_valid  <= 1'b1;
      approx_sum <= s1_approx;
      exact_sum  <= s1_exact;
      err_dist   <= dist_c;
      err_flag   <= (dist_c != 17'd0);
    end else if (out_xfer) begin
      out_valid  <= 1'b0;
    end
  end

  // Statistics count delivered results only; clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else if (out_xfer) begin
      sample_cnt <= (sample_cnt == CNT_MAX) ? sample_cnt : sample_cnt + CNT_W'(1);
      if (err_flag && (err_cnt != CNT_MAX))
        err_cnt <= err_cnt + CNT_W'(1);
      if (err_dist > max_ed)
        max_ed <= err_dist;
      sum_ed <= sum_next[ACC_W] ? ACC_MAX : sum_next[ACC_W-1:0];
    end
  end

endmodule

// File: tb/tb_eta2_error_monitor.sv
// Self-checking bench for eta2_error_monitor: directed scenarios plus a
// randomized run against an arithmetic reference model with a result queue.
module tb_eta2_error_monitor;

  localparam int CW = 6;
  localparam int AW = 18;
  localparam longint CMAX = (64'd1 << CW) - 1;
  localparam longint AMAX = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   a = '0;
  logic [15:0]   b = '0;
  logic          cin = 1'b0;
  logic          clear = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [16:0]   approx_sum, exact_sum, err_dist, max_ed;
  logic          err_flag;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [AW-1:0] sum_ed;

  int tests = 0;
  int fails = 0;

  eta2_error_monitor #(.CNT_W(CW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .approx_sum(approx_sum), .exact_sum(exact_sum),
    .err_dist(err_dist), .err_flag(err_flag), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .max_ed(max_ed), .sum_ed(sum_ed)
  );

  always #5 clk = ~clk;

  // Reference ETA2: per 4-bit block, add the speculative carry from the block below.
  function automatic logic [16:0] ref_approx(input logic [15:0] x, input logic [15:0] z, input logic ci);
    int res, c, xk, zk;
    res = 0;
    c = int'(ci);
    for (int k = 0; k < 4; k++) begin
      xk  = int'((x >> (4*k)) & 16'hF);
      zk  = int'((z >> (4*k)) & 16'hF);
      res = res + (((xk + zk + c) % 16) << (4*k));
      c   = (xk + zk > 15) ? 1 : 0;
    end
    res = res + (c << 16);
    return res[16:0];
  endfunction

  function automatic logic [16:0] ref_exact(input logic [15:0] x, input logic [15:0] z, input logic ci);
    int res;
    res = int'(x) + int'(z) + int'(ci);
    return res[16:0];
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h4321; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_in_ready: got %h expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_out_valid: got %h expected 0", out_valid); end
    tests++; if (approx_sum !== 17'h0 || exact_sum !== 17'h0 || err_dist !== 17'h0) begin fails++; $display("[TB] FAIL rst_results: got %h/%h/%h expected 0", approx_sum, exact_sum, err_dist); end
    tests++; if (sample_cnt !== '0 || err_cnt !== '0 || max_ed !== '0 || sum_ed !== '0) begin fails++; $display("[TB] FAIL rst_stats: got %h/%h/%h/%h expected 0", sample_cnt, err_cnt, max_ed, sum_ed); end
    // Transfer is accepted on the very edge after rst_n returns high.
    rst_n = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || exact_sum !== 17'h00100) begin fails++; $display("[TB] FAIL rst_first_xfer: got v=%h exact=%h expected v=1 exact=00100", out_valid, exact_sum); end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_clear();
  endtask

  task automatic test_latency();
    logic [15:0] va [3] = '{16'h00FF, 16'hFFFF, 16'h000F};
    logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'h0000};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [16:0] xe [3] = '{17'h00100, 17'h10000, 17'h00010};
    logic [16:0] xa [3] = '{17'h00000, 17'h0FF00, 17'h00000};
    logic [16:0] xd [3] = '{17'h00100, 17'h00100, 17'h00010};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL lat_early_%0d: got %h expected 0", i, out_valid); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL lat_valid_%0d: got %h expected 1", i, out_valid); end
      tests++; if (exact_sum !== xe[i]) begin fails++; $display("[TB] FAIL lat_exact_%0d: got %h expected %h", i, exact_sum, xe[i]); end
      tests++; if (approx_sum !== xa[i]) begin fails++; $display("[TB] FAIL lat_approx_%0d: got %h expected %h", i, approx_sum, xa[i]); end
      tests++; if (err_dist !== xd[i] || err_flag !== 1'b1) begin fails++; $display("[TB] FAIL lat_err_%0d: got %h/%h expected %h/1", i, err_dist, err_flag, xd[i]); end
    end
    @(posedge clk); #1;
    tests++; if (sample_cnt !== CW'(3) || err_cnt !== CW'(3)) begin fails++; $display("[TB] FAIL lat_counts: got %0d/%0d expected 3/3", sample_cnt, err_cnt); end
    tests++; if (max_ed !== 17'h100 || sum_ed !== AW'(18'h210)) begin fails++; $display("[TB] FAIL lat_ed: got %h/%h expected 100/210", max_ed, sum_ed); end
  endtask

  task automatic test_stall();
    logic [15:0] pa [3] = '{16'h1234, 16'h0FFF, 16'hABCD};
    logic [15:0] pb [3] = '{16'h4321, 16'h0001, 16'h1111};
    logic        pc [3] = '{1'b0, 1'b0, 1'b1};
    int acc = 0;
    out_ready = 1'b0; in_valid = 1'b1; a = pa[0]; b = pb[0]; cin = pc[0];
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (cyc >= 2) begin
        tests++;
        if (out_valid !== 1'b1 || exact_sum !== ref_exact(pa[0], pb[0], pc[0]) || approx_sum !== ref_approx(pa[0], pb[0], pc[0])) begin
          fails++; $display("[TB] FAIL stall_hold_%0d: got v=%h %h/%h expected v=1 %h/%h", cyc, out_valid, exact_sum, approx_sum, ref_exact(pa[0], pb[0], pc[0]), ref_approx(pa[0], pb[0], pc[0]));
        end
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      if (acc < 3) begin a = pa[acc]; b = pb[acc]; cin = pc[acc]; end
    end
    tests++; if (acc != 2) begin fails++; $display("[TB] FAIL stall_accepted: got %0d expected 2", acc); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_in_ready: got %h expected 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || exact_sum !== ref_exact(pa[i], pb[i], pc[i]) || approx_sum !== ref_approx(pa[i], pb[i], pc[i])) begin
        fails++; $display("[TB] FAIL stall_release_%0d: got v=%h %h/%h expected v=1 %h/%h", i, out_valid, exact_sum, approx_sum, ref_exact(pa[i], pb[i], pc[i]), ref_approx(pa[i], pb[i], pc[i]));
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      if (acc >= 3) in_valid = 1'b0;
    end
    tests++; if (acc != 3) begin fails++; $display("[TB] FAIL stall_total: got %0d expected 3", acc); end
  endtask

  task automatic test_stream(input bit with_clear);
    logic [15:0] sa [3] = '{16'h00FF, 16'h0001, 16'hFFFF};
    logic [15:0] sb [3] = '{16'h0001, 16'h0001, 16'h0001};
    logic [16:0] se [3] = '{17'h00100, 17'h00002, 17'h10000};
    int sent = 0;
    int got = 0;
    do_clear();
    out_ready = 1'b1; in_valid = 1'b1; a = sa[0]; b = sb[0]; cin = 1'b0;
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        tests++; if (exact_sum !== se[got]) begin fails++; $display("[TB] FAIL stream_result_%0d: got %h expected %h", got, exact_sum, se[got]); end
        if (with_clear && got == 2) clear = 1'b1;
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      clear = 1'b0;
      if (sent < 3) begin a = sa[sent]; b = sb[sent]; end
      else in_valid = 1'b0;
    end
    tests++; if (got != 3) begin fails++; $display("[TB] FAIL stream_timeout: got %0d results expected 3", got); end
    if (with_clear) begin
      tests++; if (sample_cnt !== '0 || err_cnt !== '0 || max_ed !== '0 || sum_ed !== '0) begin fails++; $display("[TB] FAIL clear_stats: got %h/%h/%h/%h expected 0", sample_cnt, err_cnt, max_ed, sum_ed); end
    end else begin
      tests++; if (sample_cnt !== CW'(3) || err_cnt !== CW'(2)) begin fails++; $display("[TB] FAIL stream_counts: got %0d/%0d expected 3/2", sample_cnt, err_cnt); end
      tests++; if (max_ed !== 17'h100 || sum_ed !== AW'(18'h200)) begin fails++; $display("[TB] FAIL stream_ed: got %h/%h expected 100/200", max_ed, sum_ed); end
    end
  endtask

  task automatic test_reset_midflight();
    bit full = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    for (int cyc = 0; cyc < 6 && !full; cyc++) begin
      @(posedge clk); #1;
      if (!in_ready) full = 1'b1;
    end
    tests++; if (!full || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL midrst_fill: got full=%0d v=%h expected full=1 v=1", full, out_valid); end
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_handshake: got v=%h rdy=%h expected v=0 rdy=1", out_valid, in_ready); end
    tests++; if (sample_cnt !== '0 || err_cnt !== '0 || max_ed !== '0 || sum_ed !== '0) begin fails++; $display("[TB] FAIL midrst_stats: got %h/%h/%h/%h expected 0", sample_cnt, err_cnt, max_ed, sum_ed); end
    rst_n = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_stale_%0d: got %h expected 0", cyc, out_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int got = 0;
    do_clear();
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h0FF0; b = 16'h0010; cin = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 70; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (got == 0) begin
          tests++; if (err_dist !== 17'h01000) begin fails++; $display("[TB] FAIL sat_err_dist: got %h expected 01000", err_dist); end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (got != 70) begin fails++; $display("[TB] FAIL sat_timeout: got %0d expected 70", got); end
    tests++; if (sample_cnt !== CW'(CMAX) || err_cnt !== CW'(CMAX)) begin fails++; $display("[TB] FAIL sat_counts: got %0d/%0d expected %0d", sample_cnt, err_cnt, CMAX); end
    tests++; if (max_ed !== 17'h01000 || sum_ed !== AW'(AMAX)) begin fails++; $display("[TB] FAIL sat_ed: got %h/%h expected 01000/%h", max_ed, sum_ed, AMAX); end
  endtask

  task automatic test_random();
    logic [16:0] qa[$];
    logic [16:0] qe[$];
    int          qage[$];
    longint ms = 0, me = 0, mmax = 0, msum = 0;
    logic [16:0] ea, ee, ed;
    bit exp_ir, exp_ov, inx, outx;
    do_clear();
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 6;
      clear     = ($urandom % 100) == 0;
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      if ($urandom % 4 == 0) a = 16'hFFFF;
      @(negedge clk);
      exp_ir = (qa.size() < 2) || out_ready;
      exp_ov = (qa.size() > 0) && (qage[0] >= 1);
      tests++; if (in_ready !== exp_ir) begin fails++; $display("[TB] FAIL rnd_in_ready@%0d: got %h expected %h", cyc, in_ready, exp_ir); end
      tests++; if (out_valid !== exp_ov) begin fails++; $display("[TB] FAIL rnd_out_valid@%0d: got %h expected %h", cyc, out_valid, exp_ov); end
      if (exp_ov) begin
        ea = qa[0]; ee = qe[0];
        ed = (ee >= ea) ? ee - ea : ea - ee;
        tests++;
        if (approx_sum !== ea || exact_sum !== ee || err_dist !== ed || err_flag !== (ed != 0)) begin
          fails++; $display("[TB] FAIL rnd_result@%0d: got %h/%h/%h/%h expected %h/%h/%h/%h", cyc, approx_sum, exact_sum, err_dist, err_flag, ea, ee, ed, (ed != 0));
        end
      end
      tests++;
      if (sample_cnt !== CW'(ms) || err_cnt !== CW'(me) || max_ed !== 17'(mmax) || sum_ed !== AW'(msum)) begin
        fails++; $display("[TB] FAIL rnd_stats@%0d: got %0d/%0d/%h/%h expected %0d/%0d/%h/%h", cyc, sample_cnt, err_cnt, max_ed, sum_ed, ms, me, mmax, msum);
      end
      inx  = in_valid && exp_ir;
      outx = exp_ov && out_ready;
      @(posedge clk);
      foreach (qage[i]) qage[i]++;
      if (outx) begin
        ea = qa.pop_front(); ee = qe.pop_front(); void'(qage.pop_front());
        ed = (ee >= ea) ? ee - ea : ea - ee;
        if (!clear) begin
          ms   = (ms + 1 > CMAX) ? CMAX : ms + 1;
          if (ed != 0) me = (me + 1 > CMAX) ? CMAX : me + 1;
          if (longint'(ed) > mmax) mmax = longint'(ed);
          msum = (msum + longint'(ed) > AMAX) ? AMAX : msum + longint'(ed);
        end
      end
      if (clear) begin ms = 0; me = 0; mmax = 0; msum = 0; end
      if (inx) begin
        qa.push_back(ref_approx(a, b, cin));
        qe.push_back(ref_exact(a, b, cin));
        qage.push_back(0);
      end
      #1;
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_stream(1'b0);
    test_reset_midflight();
    test_stream(1'b1);
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eta2_error_monitor.md
ETA2_ERROR_MONITOR -- requirements
Module: eta2_error_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of sample_cnt and err_cnt.
REQ-002 SHALL have parameter ACC_W, default 48, width of sum_ed.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a, b  input  16 each  operands.
REQ-008 cin  input  1  carry-in.
REQ-009 clear  input  1  synchronous statistics clear.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 approx_sum  output  17  ETA2 result {cout, Y}.
REQ-013 exact_sum  output  17  a+b+cin.
REQ-014 err_dist  output  17  |exact_sum - approx_sum|.
REQ-015 err_flag  output  1  err_dist != 0.
REQ-016 sample_cnt, err_cnt  output  CNT_W each  results counted, erroneous results counted.
REQ-017 max_ed  output  17  largest err_dist counted.
REQ-018 sum_ed  output  ACC_W  sum of counted err_dist.

Function
REQ-019 Approx model SHALL split operands into four 4-bit blocks k=0..3; block k sum = (a_k + b_k + c_k) mod 16; c_0 = cin; c_k (k=1..3) = carry-out of a_(k-1)+b_(k-1) with no carry-in; approx bit 16 = carry-out of a_3+b_3 with no carry-in.
REQ-020 exact_sum SHALL be the full 17-bit a+b+cin.
REQ-021 Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-022 Pipeline SHALL be two stages: stage 1 registers approx_sum/exact_sum; stage 2 registers all outputs plus err_dist, err_flag.
REQ-023 Stage 2 SHALL load when stage 1 valid && (!out_valid || out_ready); stage 1 SHALL load when in_valid && (!s1_valid || stage-2 load).
REQ-024 in_ready SHALL equal !s1_valid || (!out_valid || out_ready) (combinational path from out_ready permitted).
REQ-025 Latency: input accepted cycle N SHALL appear with out_valid=1 at cycle N+2 when unstalled; throughput one per cycle.
REQ-026 Stalled result SHALL hold all result outputs stable while out_valid && !out_ready; no loss, no duplication, order preserved.
REQ-027 Statistics SHALL update only on output transfer, visible next cycle: sample_cnt+1; err_cnt+1 if err_flag; max_ed = max(max_ed, err_dist); sum_ed += err_dist.
REQ-028 sample_cnt, err_cnt, sum_ed SHALL saturate at all-ones, never wrap.
REQ-029 clear SHALL zero all four statistics next cycle; clear coincident with an output transfer: clear wins, that result delivered but not counted.
REQ-030 clear SHALL NOT affect pipeline contents or handshake.

Reset
REQ-031 rst_n=0 at a clock edge SHALL clear s1_valid, out_valid, all result outputs and all statistics to 0; in-flight operands discarded.
REQ-032 During reset in_ready SHALL read 1 after first reset edge; first transfer allowed the cycle rst_n returns to 1.

Verification
REQ-033 a=0x00FF, b=0x0001, cin=0 -> exact 0x00100, approx 0x00000, err_dist 0x100, err_flag 1, output 2 cycles after accept.
REQ-034 a=0xFFFF, b=0x0001, cin=0 -> exact 0x10000, approx 0x0FF00, err_dist 0x100; a=0x000F, b=0x0000, cin=1 -> exact 0x10, approx 0x00, err_dist 0x10.
REQ-035 out_ready=0 for 6 cycles, in_valid=1 continuously with 3 distinct pairs -> exactly 2 accepted, in_ready=0 after, outputs stable; release -> 3 results in order, no gaps.
REQ-036 Stream {0x00FF+0x0001, 0x0001+0x0001, 0xFFFF+0x0001} all delivered -> sample_cnt 3, err_cnt 2, max_ed 0x100, sum_ed 0x200.
REQ-037 clear asserted same cycle as third transfer above -> next cycle all statistics 0; result still delivered.
REQ-038 rst_n low with out_valid=1 and s1_valid=1 -> next cycle out_valid 0, all statistics 0, no stale result emitted after release.
